bp_decode_ctrl: RTL and testbench

Sequencing controller for the BP decoder core behind the BPDecodeIP AXI4-Lite register bank. It accepts a start command and iteration limit from the register bank and loads one codeword of LLRs from an input stream into the core. It then alternates check-node and variable-node passes until the syndrome clears or the iteration limit is reached, and streams hard decisions out. It reports busy, done, pass and the iteration count back to the register bank and raises a one-cycle interrupt on completion.

---
 rtl/bp_ctrl_pkg.sv | 17 +
 rtl/bp_decode_ctrl.sv | 151 +++++++++++++++
 tb/tb_bp_decode_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_ctrl_pkg.sv
// rtl/bp_ctrl_pkg.sv - shared types and defaults for the BP decoder sequencing controller
package bp_ctrl_pkg;

    localparam int DEFAULT_CW_LEN = 64;
    localparam int DEFAULT_ITER_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CN,
        ST_VN,
        ST_CHECK,
        ST_UNLOAD,
        ST_DONE
    } ctrl_state_e;

endpackage

// File: rtl/bp_decode_ctrl.sv
// rtl/bp_decode_ctrl.sv - loads a codeword, iterates CN/VN passes, unloads hard decisions
module bp_decode_ctrl
    import bp_ctrl_pkg::*;
#(
    parameter int CW_LEN = DEFAULT_CW_LEN,
    parameter int ITER_W = DEFAULT_ITER_W,
    localparam int AW = $clog2(CW_LEN)
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic              cfg_clear,
    input  logic [ITER_W-1:0] cfg_max_iter,
    input  logic              cfg_early_stop,
    output logic              status_busy,
    output logic              status_done,
    output logic              status_pass,
    output logic [ITER_W-1:0] status_iter,
    output logic              irq,
    input  logic              llr_valid,
    output logic              llr_ready,
    output logic              core_load_en,
    output logic [AW-1:0]     core_addr,
    output logic              core_cn_start,
    input  logic              core_cn_done,
    output logic              core_vn_start,
    input  logic              core_vn_done,
    input  logic              core_syn_ok,
    output logic              bit_valid,
    input  logic              bit_ready
);

    localparam logic [AW:0] LAST_BEAT = (AW+1)'(CW_LEN - 1);

    ctrl_state_e       state;
    logic [AW:0]       beat_cnt;
    logic [ITER_W-1:0] max_iter_q;
    logic              early_stop_q;
    logic              syn_ok_q;
    logic              cn_start_q;
    logic              vn_start_q;

    logic load_fire;
    logic unload_fire;
    logic last_beat;
    logic abort_ok;

    assign load_fire   = (state == ST_LOAD) && llr_valid;
    assign unload_fire = (state == ST_UNLOAD) && bit_ready;
    assign last_beat   = (beat_cnt == LAST_BEAT);
    assign abort_ok    = cfg_abort && (state != ST_IDLE) && (state != ST_DONE);

    assign status_busy   = (state != ST_IDLE);
    assign llr_ready     = (state == ST_LOAD);
    assign core_load_en  = load_fire;
    assign bit_valid     = (state == ST_UNLOAD);
    assign irq           = (state == ST_DONE);
    assign core_cn_start = cn_start_q;
    assign core_vn_start = vn_start_q;
    assign core_addr     = ((state == ST_LOAD) || (state == ST_UNLOAD)) ? beat_cnt[AW-1:0] : '0;

    // Start pulses are raised on the transition into CN/VN so they last exactly one cycle.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state        <= ST_IDLE;
            beat_cnt     <= '0;
            max_iter_q   <= '0;
            early_stop_q <= 1'b0;
            syn_ok_q     <= 1'b0;
            status_iter  <= '0;
            cn_start_q   <= 1'b0;
            vn_start_q   <= 1'b0;
        end else begin
            cn_start_q <= 1'b0;
            vn_start_q <= 1'b0;
            if (abort_ok) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cfg_start) begin
                            max_iter_q   <= (cfg_max_iter == '0) ? ITER_W'(1) : cfg_max_iter;
                            early_stop_q <= cfg_early_stop;
                            status_iter  <= '0;
                            syn_ok_q     <= 1'b0;
                            beat_cnt     <= '0;
                            state        <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        if (load_fire) begin
                            beat_cnt <= beat_cnt + 1'b1;
                            if (last_beat) begin
                                state      <= ST_CN;
                                cn_start_q <= 1'b1;
                            end
                        end
                    end
                    ST_CN: begin
                        if (core_cn_done) begin
                            state      <= ST_VN;
                            vn_start_q <= 1'b1;
                        end
                    end
                    ST_VN: begin
                        if (core_vn_done) begin
                            syn_ok_q    <= core_syn_ok;
                            status_iter <= status_iter + 1'b1;
                            state       <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        if ((early_stop_q && syn_ok_q) || (status_iter == max_iter_q)) begin
                            beat_cnt <= '0;
                            state    <= ST_UNLOAD;
                        end else begin
                            state      <= ST_CN;
                            cn_start_q <= 1'b1;
                        end
                    end
                    ST_UNLOAD: begin
                        if (unload_fire) begin
                            beat_cnt <= beat_cnt + 1'b1;
                            if (last_beat) begin
                                state <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // A completion in the same cycle as cfg_clear takes priority over the clear.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            status_done <= 1'b0;
            status_pass <= 1'b0;
        end else if (state == ST_DONE) begin
            status_done <= 1'b1;
            status_pass <= syn_ok_q;
        end else if (cfg_clear) begin
            status_done <= 1'b0;
            status_pass <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bp_decode_ctrl.sv
// tb/tb_bp_decode_ctrl.sv - directed self-checking bench for bp_decode_ctrl
module tb_bp_decode_ctrl;

    localparam int CW_LEN = 16;
    localparam int ITER_W = 6;
    localparam int AW     = 4;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic              cfg_start, cfg_abort, cfg_clear, cfg_early_stop;
    logic [ITER_W-1:0] cfg_max_iter;
    logic              status_busy, status_done, status_pass, irq;
    logic [ITER_W-1:0] status_iter;
    logic              llr_valid, llr_ready, core_load_en;
    logic [AW-1:0]     core_addr;
    logic              core_cn_start, core_cn_done, core_vn_start, core_vn_done, core_syn_ok;
    logic              bit_valid, bit_ready;

    bp_decode_ctrl #(.CW_LEN(CW_LEN), .ITER_W(ITER_W)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_clear(cfg_clear),
        .cfg_max_iter(cfg_max_iter), .cfg_early_stop(cfg_early_stop),
        .status_busy(status_busy), .status_done(status_done), .status_pass(status_pass),
        .status_iter(status_iter), .irq(irq),
        .llr_valid(llr_valid), .llr_ready(llr_ready), .core_load_en(core_load_en),
        .core_addr(core_addr),
        .core_cn_start(core_cn_start), .core_cn_done(core_cn_done),
        .core_vn_start(core_vn_start), .core_vn_done(core_vn_done), .core_syn_ok(core_syn_ok),
        .bit_valid(bit_valid), .bit_ready(bit_ready)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Per-job observations, reset whenever an accepted start is seen.
    int load_cnt, unload_cnt, exp_load, exp_unload, addr_err, hold_err;
    int cn_cnt, vn_cnt, irq_cnt;
    int last_load_cyc, last_unload_cyc, first_cn_cyc, second_cn_cyc, first_vn_done_cyc, irq_cyc;
    bit hold_pend;
    logic [AW-1:0] hold_addr;

    always @(negedge ACLK) begin
        if (ARESET) begin
            hold_pend = 1'b0;
        end else begin
            if (cfg_start && !status_busy) begin
                load_cnt = 0; unload_cnt = 0; exp_load = 0; exp_unload = 0;
                addr_err = 0; hold_err = 0; cn_cnt = 0; vn_cnt = 0; irq_cnt = 0;
                last_load_cyc = -1; last_unload_cyc = -1; first_cn_cyc = -1;
                second_cn_cyc = -1; first_vn_done_cyc = -1; irq_cyc = -1;
            end
            if (core_load_en) begin
                if (core_addr != exp_load[AW-1:0]) addr_err++;
                if (core_addr == AW'(CW_LEN - 1)) last_load_cyc = cyc;
                exp_load++;
                load_cnt++;
            end
            if (bit_valid && bit_ready) begin
                if (core_addr != exp_unload[AW-1:0]) addr_err++;
                if (core_addr == AW'(CW_LEN - 1)) last_unload_cyc = cyc;
                exp_unload++;
                unload_cnt++;
            end
            if (hold_pend && (!bit_valid || core_addr != hold_addr)) hold_err++;
            hold_pend = bit_valid && !bit_ready;
            hold_addr = core_addr;
            if (core_cn_start) begin
                cn_cnt++;
                if (cn_cnt == 1) first_cn_cyc = cyc;
                if (cn_cnt == 2) second_cn_cyc = cyc;
            end
            if (core_vn_done && first_vn_done_cyc < 0) first_vn_done_cyc = cyc;
            if (core_vn_start) vn_cnt++;
            if (irq) begin
                irq_cnt++;
                irq_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    logic start_ready;
    logic aborted, abort_busy, abort_vn;
    int   end_cyc;

    // Runs one job with a small behavioural core; syn_iter=0 means syndrome never clears.
    task automatic run_job(input int mi, input bit es, input int syn_iter, input bit rnd,
                           input int abort_iter, input bit clr_at_done, input bit start_mid,
                           input int rst_after);
        int guard = 0;
        int cn_dly = 0, vn_dly = 0, vn_seen = 0;
        bit cn_pend = 0, vn_pend = 0;
        aborted = 1'b0;
        cfg_max_iter   = ITER_W'(mi);
        cfg_early_stop = es;
        cfg_start      = 1'b1;
        tick();
        cfg_start   = 1'b0;
        start_ready = llr_ready;
        while (status_busy && guard < 3000) begin
            if (rst_after != 0 && unload_cnt >= rst_after) break;
            llr_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            bit_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            cfg_start = start_mid && (load_cnt == 5);
            cfg_clear = clr_at_done && irq;
            cfg_abort = 1'b0;
            if (core_cn_start) begin
                cn_pend = 1;
                cn_dly  = rnd ? int'($urandom_range(0, 2)) : 0;
            end
            if (core_vn_start) begin
                vn_seen++;
                if (abort_iter != 0 && vn_seen == abort_iter) begin
                    cfg_abort = 1'b1;
                end else begin
                    vn_pend = 1;
                    vn_dly  = rnd ? int'($urandom_range(0, 2)) : 0;
                end
            end
            core_cn_done = cn_pend && cn_dly == 0;
            core_vn_done = vn_pend && vn_dly == 0;
            core_syn_ok  = core_vn_done && syn_iter != 0 && vn_seen >= syn_iter;
            tick();
            if (cfg_abort) begin
                aborted    = 1'b1;
                abort_busy = status_busy;
                abort_vn   = core_vn_start;
            end
            if (core_cn_done) cn_pend = 0; else if (cn_pend) cn_dly--;
            if (core_vn_done) vn_pend = 0; else if (vn_pend) vn_dly--;
            guard++;
        end
        end_cyc = cyc;
        {cfg_start, cfg_abort, cfg_clear, llr_valid, bit_ready} = '0;
        {core_cn_done, core_vn_done, core_syn_ok} = '0;
        chk("job_timeout", guard < 3000, 1);
    endtask

    task automatic pulse_clear();
        cfg_clear = 1'b1;
        tick();
        cfg_clear = 1'b0;
    endtask

    initial begin
        ARESET = 1'b1;
        {cfg_start, cfg_abort, cfg_clear, cfg_early_stop, llr_valid, bit_ready} = '0;
        {core_cn_done, core_vn_done, core_syn_ok} = '0;
        cfg_max_iter = '0;
        repeat (3) tick();
        #2 ARESET = 1'b0;
        tick();

        chk("rst_busy", status_busy, 0);
        chk("rst_done", status_done, 0);
        chk("rst_pass", status_pass, 0);
        chk("rst_iter", status_iter, 0);
        chk("rst_irq", irq, 0);
        chk("rst_llr_ready", llr_ready, 0);
        chk("rst_bit_valid", bit_valid, 0);
        chk("rst_addr", core_addr, 0);
        chk("rst_cn_start", core_cn_start, 0);

        // max_iter=3, no early stop, syndrome always clean
        run_job(3, 0, 1, 0, 0, 0, 0, 0);
        chk("t1_start_ready", start_ready, 1);
        chk("t1_cn_cnt", cn_cnt, 3);
        chk("t1_vn_cnt", vn_cnt, 3);
        chk("t1_iter", status_iter, 3);
        chk("t1_pass", status_pass, 1);
        chk("t1_done", status_done, 1);
        chk("t1_irq_cnt", irq_cnt, 1);
        chk("t1_load_cnt", load_cnt, 16);
        chk("t1_unload_cnt", unload_cnt, 16);
        chk("t1_addr_err", addr_err, 0);
        chk("t1_load_to_cn", first_cn_cyc - last_load_cyc, 1);
        chk("t1_vn_to_cn", second_cn_cyc - first_vn_done_cyc, 2);
        chk("t1_unload_to_irq", irq_cyc - last_unload_cyc, 1);
        chk("t1_irq_to_idle", end_cyc - irq_cyc, 1);

        pulse_clear();
        chk("clr_done", status_done, 0);
        chk("clr_pass", status_pass, 0);

        // early stop on second iteration
        run_job(10, 1, 2, 0, 0, 0, 0, 0);
        chk("t2_iter", status_iter, 2);
        chk("t2_pass", status_pass, 1);
        chk("t2_cn_cnt", cn_cnt, 2);
        chk("t2_unload_cnt", unload_cnt, 16);

        // max_iter=0 runs exactly one iteration
        run_job(0, 0, 0, 0, 0, 0, 0, 0);
        chk("t3_iter", status_iter, 1);
        chk("t3_pass", status_pass, 0);
        chk("t3_done", status_done, 1);
        chk("t3_cn_cnt", cn_cnt, 1);

        // random stream gaps with an ignored mid-load start
        run_job(2, 0, 0, 1, 0, 0, 1, 0);
        chk("t4_load_cnt", load_cnt, 16);
        chk("t4_unload_cnt", unload_cnt, 16);
        chk("t4_addr_err", addr_err, 0);
        chk("t4_hold_err", hold_err, 0);
        chk("t4_iter", status_iter, 2);
        chk("t4_irq_cnt", irq_cnt, 1);

        // abort during the second VN pass, then a clean job
        pulse_clear();
        run_job(5, 0, 0, 0, 2, 0, 0, 0);
        chk("t5_aborted", aborted, 1);
        chk("t5_abort_busy", abort_busy, 0);
        chk("t5_abort_vn_start", abort_vn, 0);
        chk("t5_irq_cnt", irq_cnt, 0);
        chk("t5_done", status_done, 0);
        chk("t5_vn_cnt", vn_cnt, 2);
        run_job(1, 0, 1, 0, 0, 0, 0, 0);
        chk("t5b_done", status_done, 1);
        chk("t5b_iter", status_iter, 1);
        chk("t5b_irq_cnt", irq_cnt, 1);

        // cfg_clear coincident with DONE loses to the set
        pulse_clear();
        chk("t6_pre_done", status_done, 0);
        run_job(1, 0, 1, 0, 0, 1, 0, 0);
        chk("t6_done", status_done, 1);
        chk("t6_pass", status_pass, 1);

        // asynchronous reset in the middle of UNLOAD
        run_job(1, 0, 1, 0, 0, 0, 0, 5);
        chk("t7_in_unload", bit_valid, 1);
        #2 ARESET = 1'b1;
        #1;
        chk("t7_busy", status_busy, 0);
        chk("t7_bit_valid", bit_valid, 0);
        chk("t7_addr", core_addr, 0);
        chk("t7_done", status_done, 0);
        chk("t7_iter", status_iter, 0);
        #3 ARESET = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
